// File: rtl/cpstr_esc_pkg.sv
// Control port shared definitions.
// Holds the escape byte value used by both the transmit-side escaper and the
// receive-side de-escaper, so the two ends of the link share one definition
// of the framing byte.
package cpstr_esc_pkg;

   // Default escape (framing) byte for the control port byte link.
   localparam logic [7:0] CP_ESC_CHAR = 8'd27;

endpackage : cpstr_esc_pkg

// File: rtl/cpstr_esc.sv
// Control port stream escaper.
// Merges a main byte stream and an escape (control) byte stream into a single
// byte stream for the control port transmit link.
//   - Main bytes pass through unchanged; a main byte equal to ESC_CHAR is sent
//     twice (ESC_CHAR, ESC_CHAR).
//   - Each escape byte is sent as ESC_CHAR followed by the escape byte.
//   - An escape byte equal to ESC_CHAR cannot be encoded; it is consumed,
//     dropped, and flagged with a one-cycle o_esc_err pulse.
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_data/i_valid/o_ready     main stream input (valid/ready)
//   i_esc_data/i_esc_valid/
//   o_esc_ready                escape stream input (strict priority)
//   o_data/o_valid/i_ready     merged output stream (registered)
//   o_esc_err                  dropped-escape pulse
module cpstr_esc
   import cpstr_esc_pkg::*;
#(
   parameter logic [7:0] ESC_CHAR = CP_ESC_CHAR
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic [7:0] i_esc_data,
   input  logic       i_esc_valid,
   output logic       o_esc_ready,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_esc_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREFIX,
      ST_BYTE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] hold_q,  hold_d;
   logic       err_q,   err_d;
   logic       can_acc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   // A new byte may enter when nothing is queued, or when the last byte of the
   // current output is leaving this cycle. ST_PREFIX never accepts, which keeps
   // each ESC_CHAR pair contiguous on the link.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      err_d   = 1'b0;
      can_acc = (state_q == ST_IDLE) || ((state_q == ST_BYTE) && i_ready);

      case (state_q)
         ST_IDLE:   state_d = ST_IDLE;
         ST_PREFIX: if (i_ready) state_d = ST_BYTE;
         ST_BYTE:   if (i_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (can_acc) begin
         if (i_esc_valid) begin
            if (i_esc_data == ESC_CHAR) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               hold_d  = i_esc_data;
               state_d = ST_PREFIX;
            end
         end else if (i_valid) begin
            hold_d  = i_data;
            // A literal ESC_CHAR is doubled: the prefix state sends the first
            // copy, hold supplies the second.
            state_d = (i_data == ESC_CHAR) ? ST_PREFIX : ST_BYTE;
         end
      end
   end

   assign o_esc_ready = can_acc;
   assign o_ready     = can_acc && !i_esc_valid;
   assign o_valid     = (state_q != ST_IDLE);
   assign o_data      = (state_q == ST_PREFIX) ? ESC_CHAR : hold_q;
   assign o_esc_err   = err_q;

endmodule : cpstr_esc

// File: tb/tb_cpstr_esc.sv
// Testbench for cpstr_esc: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed output byte sequences.
module tb_cpstr_esc;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       valid;
   logic       o_ready;
   logic [7:0] esc_data;
   logic       esc_valid;
   logic       o_esc_ready;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_esc_err;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned cyc = 0;
   int unsigned errcnt = 0;
   bit          rnd_ready = 0;

   logic [7:0]  mq[$];
   logic [7:0]  last_b = '0;
   logic        err_exp = 1'b0;
   logic [7:0]  log_q[$];
   int unsigned log_cyc[$];

   cpstr_esc #(.ESC_CHAR(8'd27)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_data     (data),
      .i_valid    (valid),
      .o_ready    (o_ready),
      .i_esc_data (esc_data),
      .i_esc_valid(esc_valid),
      .o_esc_ready(o_esc_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_esc_err  (o_esc_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: a queue of bytes still owed to the link. Its front is
   // what must be on o_data; new input fits when at most the leaving byte remains.
   always @(negedge clk) begin
      bit can;
      if (rst) begin
         mq.delete();
         last_b  = '0;
         err_exp = 1'b0;
      end else begin
         can = (mq.size() == 0) || (mq.size() == 1 && i_ready);
         chk("o_valid",     {7'd0, o_valid},     {7'd0, mq.size() != 0});
         chk("o_data",      o_data,              (mq.size() != 0) ? mq[0] : last_b);
         chk("o_esc_err",   {7'd0, o_esc_err},   {7'd0, err_exp});
         chk("o_esc_ready", {7'd0, o_esc_ready}, {7'd0, can});
         chk("o_ready",     {7'd0, o_ready},     {7'd0, can && !esc_valid});
         if (o_valid && i_ready) begin
            log_q.push_back(o_data);
            log_cyc.push_back(cyc);
         end
         if (o_esc_err) errcnt++;
         err_exp = 1'b0;
         if (i_ready && mq.size() != 0) void'(mq.pop_front());
         if (can) begin
            if (esc_valid) begin
               if (esc_data == 8'd27) err_exp = 1'b1;
               else begin
                  mq.push_back(8'd27); mq.push_back(esc_data); last_b = esc_data;
               end
            end else if (valid) begin
               if (data == 8'd27) begin
                  mq.push_back(8'd27); mq.push_back(8'd27);
               end else mq.push_back(data);
               last_b = data;
            end
         end
      end
      cyc++;
   end

   always @(posedge clk) begin
      if (rnd_ready) begin
         #1 i_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input bit is_esc, input logic [7:0] b);
      bit acc = 0;
      int n = 0;
      if (is_esc) begin esc_valid = 1; esc_data = b; end
      else begin valid = 1; data = b; end
      while (!acc && n < 30) begin
         @(negedge clk);
         acc = is_esc ? o_esc_ready : o_ready;
         @(posedge clk); #1;
         n++;
      end
      if (is_esc) esc_valid = 0; else valid = 0;
      vectors++;
      if (!acc) begin
         miscompares++;
         $display("FAIL accept_timeout: byte %h not accepted within %0d cycles", b, n);
      end
   endtask

   task automatic drain();
      rnd_ready = 0;
      #0 i_ready = 1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic check_log(input string name, input logic [7:0] exp[$], input bit consec);
      chk({name, "_len"}, 8'(log_q.size()), 8'(exp.size()));
      for (int i = 0; i < exp.size() && i < log_q.size(); i++)
         chk({name, "_byte"}, log_q[i], exp[i]);
      if (consec)
         for (int i = 1; i < log_cyc.size(); i++)
            chk({name, "_gap"}, 8'(log_cyc[i] - log_cyc[i-1]), 8'd1);
      log_q.delete();
      log_cyc.delete();
   endtask

   initial begin
      int unsigned e0;
      rst = 1; valid = 0; data = '0; esc_valid = 0; esc_data = '0; i_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_valid", {7'd0, o_valid}, 8'd0);
      chk("reset_data", o_data, 8'd0);
      chk("reset_err", {7'd0, o_esc_err}, 8'd0);
      @(posedge clk); #1;

      // Plain bytes back to back
      send(0, 8'h41); send(0, 8'h42); send(0, 8'h43);
      drain();
      check_log("plain", '{8'h41, 8'h42, 8'h43}, 1);

      // Literal ESC_CHAR doubled, next byte slots in behind it
      send(0, 8'h1B); send(0, 8'h44);
      drain();
      check_log("dbl", '{8'h1B, 8'h1B, 8'h44}, 1);

      // Escape byte
      e0 = errcnt;
      send(1, 8'h05);
      drain();
      check_log("esc", '{8'h1B, 8'h05}, 1);
      chk("esc_noerr", 8'(errcnt - e0), 8'd0);

      // Simultaneous escape and main: escape wins
      esc_valid = 1; esc_data = 8'h07; valid = 1; data = 8'h41;
      @(negedge clk);
      chk("prio_esc_ready", {7'd0, o_esc_ready}, 8'd1);
      chk("prio_ready", {7'd0, o_ready}, 8'd0);
      @(posedge clk); #1;
      esc_valid = 0;
      send(0, 8'h41);
      drain();
      check_log("prio", '{8'h1B, 8'h07, 8'h41}, 1);

      // Escape equal to ESC_CHAR is dropped with a single error pulse
      e0 = errcnt;
      send(1, 8'h1B);
      drain();
      chk("drop_pulses", 8'(errcnt - e0), 8'd1);
      send(0, 8'h42);
      drain();
      check_log("drop", '{8'h42}, 1);

      // Backpressure in the prefix state
      i_ready = 0;
      send(1, 8'h09);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", {7'd0, o_valid}, 8'd1);
         chk("bp_data", o_data, 8'h1B);
         chk("bp_esc_ready", {7'd0, o_esc_ready}, 8'd0);
         @(posedge clk); #1;
      end
      drain();
      check_log("bp", '{8'h1B, 8'h09}, 1);

      // Reset while a byte is waiting on the link
      i_ready = 0;
      send(0, 8'h55);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("rst_valid", {7'd0, o_valid}, 8'd0);
      chk("rst_data", o_data, 8'd0);
      chk("rst_err", {7'd0, o_esc_err}, 8'd0);
      @(posedge clk); #1;
      drain();
      check_log("rst", '{}, 0);

      // Mixed stream under random backpressure
      rnd_ready = 1;
      send(0, 8'h10); send(1, 8'h1B); send(0, 8'h1B); send(1, 8'h20); send(0, 8'hFF);
      drain();
      check_log("mix", '{8'h10, 8'h1B, 8'h1B, 8'h1B, 8'h20, 8'hFF}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

endmodule : tb_cpstr_esc
